par_dcom: RTL and testbench

Read-side counterpart of the packet-word compressor. It pops (DSIZE+1)-bit words from the FIFO read port, where bit DSIZE is the packet-end flag and bits DSIZE-1:0 are payload. It then replays each packet to a downstream consumer through a req/grant arbitration handshake and a per-beat valid/ready handshake. It sits between the FIFO read side and the packet sink, runs entirely in the read clock domain, and keeps packet and error statistics.

---
 rtl/par_dcom.sv | 90 +++++++++
 tb/tb_par_dcom.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/par_dcom.sv
// Packet-word decompressor: pops flagged words from the FIFO read port and
// replays each packet downstream under req/grant arbitration and valid/ready.
module par_dcom #(
  parameter int DSIZE = 4,
  parameter int PSIZE = 4
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [DSIZE:0]   rdata,
  input  logic             rempty,
  output logic             r_en,
  output logic             req,
  input  logic             grant,
  output logic [DSIZE-1:0] data,
  output logic             valid,
  output logic             pkt_end,
  input  logic             ready,
  output logic [7:0]       pkt_cnt,
  output logic             len_err
);

  localparam int CW = $clog2(PSIZE) + 1;
  localparam logic [CW-1:0] CMAX = CW'(PSIZE);

  typedef enum logic [2:0] {IDLE, REQ, LOAD, SEND, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] beat_cnt;
  logic          accept;
  logic          load_first;
  logic          load_next;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    accept     = (state == SEND) & valid & ready & grant;
    load_first = (state == LOAD) & ~rempty & grant;
    load_next  = accept & ~pkt_end & ~rempty;
    r_en       = load_first | load_next;
    state_nxt  = state;
    unique case (state)
      IDLE: if (!rempty) state_nxt = REQ;
      REQ:  if (grant) state_nxt = LOAD;
      LOAD: if (load_first) state_nxt = SEND;
      SEND: begin
        if (accept) begin
          if (pkt_end)      state_nxt = DONE;
          else if (rempty)  state_nxt = LOAD;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      req      <= 1'b0;
      data     <= '0;
      valid    <= 1'b0;
      pkt_end  <= 1'b0;
      pkt_cnt  <= 8'd0;
      len_err  <= 1'b0;
      beat_cnt <= '0;
    end else begin
      // Bus is held from the request until the packet is closed out in DONE.
      req <= (state_nxt != IDLE);
      if (r_en) begin
        data     <= rdata[DSIZE-1:0];
        pkt_end  <= rdata[DSIZE];
        valid    <= 1'b1;
        beat_cnt <= (beat_cnt == CMAX) ? CMAX : beat_cnt + 1'b1;
        if (beat_cnt == CMAX && !rdata[DSIZE]) len_err <= 1'b1;
      end else if (accept) begin
        valid <= 1'b0;
      end
      if (state == DONE) begin
        pkt_cnt  <= pkt_cnt + 8'd1;
        beat_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_par_dcom.sv
// Directed bench for par_dcom: a queue-modelled FIFO feeds the DUT and a
// scoreboard of pushed words is compared against every accepted beat.
module tb_par_dcom;

  logic       rclk = 1'b0;
  logic       rrst_n = 1'b0;
  logic [4:0] rdata = 5'd0;
  logic       rempty = 1'b1;
  logic       r_en;
  logic       req;
  logic       grant = 1'b0;
  logic [3:0] data;
  logic       valid;
  logic       pkt_end;
  logic       ready = 1'b0;
  logic [7:0] pkt_cnt;
  logic       len_err;

  logic [4:0] fifo[$];
  logic [4:0] sb[$];
  logic       hold_empty = 1'b0;
  logic       pop_now = 1'b0;
  int         n_pops = 0;
  int         valid_cycles = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  par_dcom #(.DSIZE(4), .PSIZE(4)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rdata(rdata), .rempty(rempty),
    .r_en(r_en), .req(req), .grant(grant), .data(data), .valid(valid),
    .pkt_end(pkt_end), .ready(ready), .pkt_cnt(pkt_cnt), .len_err(len_err)
  );

  always #5 rclk = ~rclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // FIFO model: pops on the edge where r_en was high; head visible after the edge.
  always @(posedge rclk) begin
    if (pop_now && fifo.size() != 0) begin
      void'(fifo.pop_front());
      n_pops++;
    end
    rempty <= hold_empty || (fifo.size() == 0);
    rdata  <= (fifo.size() != 0) ? fifo[0] : 5'd0;
  end

  // Mid-cycle monitor: a beat is accepted on the coming edge iff valid&ready&grant.
  always @(negedge rclk) begin
    pop_now = r_en && rrst_n;
    if (rrst_n && r_en) check("r_en_while_empty", rempty, 0);
    if (rrst_n && valid) valid_cycles++;
    if (rrst_n && valid && ready && grant) begin
      if (sb.size() == 0) check("extra_beat", {pkt_end, data}, 0);
      else check("beat", {27'd0, pkt_end, data}, {27'd0, sb.pop_front()});
    end
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic push(input logic [4:0] w);
    fifo.push_back(w);
    sb.push_back(w);
  endtask

  task automatic wait_pkt(input int target);
    int k = 0;
    while (pkt_cnt != target[7:0] && k < 40) begin
      tick();
      k++;
    end
    check("pkt_cnt", pkt_cnt, target);
  endtask

  task automatic wait_beat(input logic [3:0] d);
    int k = 0;
    while (!(valid && data == d) && k < 40) begin
      tick();
      k++;
    end
    check("beat_shown", {31'd0, valid && data == d}, 1);
  endtask

  initial begin
    int base;
    int k;

    // Reset held with a non-empty FIFO
    push(5'h0A); push(5'h05); push(5'h0C); push(5'h13);
    repeat (3) tick();
    check("rst_req", req, 0);
    check("rst_valid", valid, 0);
    check("rst_pkt_end", pkt_end, 0);
    check("rst_data", data, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_len_err", len_err, 0);
    check("rst_r_en", r_en, 0);
    check("rst_no_pop", n_pops, 0);

    // Nominal 4-beat packet, grant and ready held high
    grant = 1'b1;
    ready = 1'b1;
    rrst_n = 1'b1;
    valid_cycles = 0;
    k = 0;
    while (!req && k < 2) begin
      tick();
      k++;
    end
    check("req_after_reset", req, 1);
    wait_pkt(1);
    check("nominal_valid_cycles", valid_cycles, 4);
    check("nominal_req_drop", req, 0);
    check("nominal_pops", n_pops, 4);

    // Backpressure on beat 2
    base = n_pops;
    push(5'h0A); push(5'h05); push(5'h0C); push(5'h13);
    wait_beat(4'h5);
    ready = 1'b0;
    repeat (3) begin
      tick();
      check("bp_data_held", data, 4'h5);
      check("bp_valid_held", valid, 1);
      check("bp_no_pop", r_en, 0);
    end
    ready = 1'b1;
    wait_pkt(2);
    check("bp_pops", n_pops - base, 4);

    // Underrun after two words
    push(5'h06); push(5'h07);
    repeat (10) tick();
    check("ur_valid", valid, 0);
    check("ur_req", req, 1);
    check("ur_pkt_cnt", pkt_cnt, 2);
    push(5'h19);
    wait_pkt(3);

    // Grant drop mid-packet
    push(5'h01); push(5'h02); push(5'h04); push(5'h18);
    wait_beat(4'h2);
    grant = 1'b0;
    repeat (2) begin
      tick();
      check("gd_data_held", data, 4'h2);
      check("gd_valid_held", valid, 1);
      check("gd_req", req, 1);
      check("gd_no_pop", r_en, 0);
    end
    grant = 1'b1;
    wait_pkt(4);

    // Overlength packet: 6 beats with PSIZE=4
    check("ol_len_err_clear", len_err, 0);
    base = n_pops;
    push(5'h01); push(5'h02); push(5'h03); push(5'h04); push(5'h05); push(5'h16);
    k = 0;
    while (!len_err && k < 40) begin
      tick();
      k++;
    end
    check("ol_len_err_set", len_err, 1);
    check("ol_len_err_at_5th", n_pops - base, 5);
    wait_pkt(5);
    check("ol_len_err_sticky", len_err, 1);
    check("ol_pops", n_pops - base, 6);

    // Two single-word packets back to back
    base = n_pops;
    push(5'h1A); push(5'h1B);
    wait_pkt(6);
    check("sw_req_gap", req, 0);
    wait_pkt(7);
    check("sw_pops", n_pops - base, 2);

    tick();
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
